// File: rtl/logic_vec_checker.sv
// Purpose: walks {a,b,c} through all 8 vectors, compares DUT response o against EXP_TABLE, reports mismatches.
// Latency: each vector is held SETTLE+1 cycles; done pulses 8*(SETTLE+1) edges after the start is accepted.
// Backpressure: none; start is only honoured in IDLE, and requests seen while busy or in DONE are dropped.
module logic_vec_checker #(
  parameter logic [7:0]  EXP_TABLE = 8'hE8,
  parameter int unsigned SETTLE    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       a,
  output logic       b,
  output logic       c,
  input  logic       o,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_cnt,
  output logic       fail_valid,
  output logic [2:0] fail_vec
);

  localparam logic [3:0] SETTLE_L = 4'(SETTLE);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t     state;
  logic [2:0] vec;
  logic [3:0] hold_cnt;
  logic       mismatch;
  logic [3:0] err_nxt;

  // Stimulus comes straight from the vector register, so it is glitch-free.
  assign {a, b, c} = vec;

  // Compare the current response with the expected bit and form the updated error count.
  always_comb begin
    mismatch = 1'b0;
    err_nxt  = err_cnt;
    mismatch = (o != EXP_TABLE[vec]);
    err_nxt  = err_cnt + {3'b000, mismatch};
  end

  // Run sequencer: hold each vector, sample at the end of its hold window, advance or finish.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      vec        <= 3'd0;
      hold_cnt   <= 4'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_cnt    <= 4'd0;
      fail_valid <= 1'b0;
      fail_vec   <= 3'd0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            vec        <= 3'd0;
            hold_cnt   <= SETTLE_L;
            err_cnt    <= 4'd0;
            fail_valid <= 1'b0;
            fail_vec   <= 3'd0;
            pass       <= 1'b0;
            busy       <= 1'b1;
            state      <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (hold_cnt != 4'd0) begin
            hold_cnt <= hold_cnt - 4'd1;
          end else begin
            err_cnt <= err_nxt;
            if (mismatch && !fail_valid) begin
              fail_valid <= 1'b1;
              fail_vec   <= vec;
            end
            if (vec != 3'd7) begin
              vec      <= vec + 3'd1;
              hold_cnt <= SETTLE_L;
            end else begin
              // Last vector: stay on 7, and fold the final sample into pass.
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (err_nxt == 4'd0);
              state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
